// File: rtl/bsearch_pkg.sv
// Shared types and defaults for the binary-search sequencer.
// The optional WAIT timeout is enabled by defining BSEARCH_TIMEOUT_EN.
package bsearch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_W     = 32;
    localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/bsearch_step.sv
// One binary-search step: probe midpoint, the narrowed interval for a predicate
// answer, the midpoint of that narrowed interval, and whether the search ends.
module bsearch_step
    import bsearch_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic [W-1:0] lo,
    input  logic [W-1:0] hi,
    input  logic         pred,
    output logic [W-1:0] mid,
    output logic [W-1:0] lo_nxt,
    output logic [W-1:0] hi_nxt,
    output logic [W-1:0] mid_nxt,
    output logic         last
);

    // Difference-based midpoint never overflows; mid < hi keeps mid+1 in range.
    always_comb begin
        mid     = lo + ((hi - lo) >> 1);
        lo_nxt  = pred ? lo  : mid + W'(1);
        hi_nxt  = pred ? mid : hi;
        mid_nxt = lo_nxt + ((hi_nxt - lo_nxt) >> 1);
        last    = !(lo_nxt < hi_nxt);
    end

endmodule

// File: rtl/bsearch_ctrl.sv
// Binary-search sequencer over [start_lo, start_hi) driving a predicate unit.
// Define BSEARCH_TIMEOUT_EN to abort a WAIT that lasts TIMEOUT cycles.
module bsearch_ctrl
    import bsearch_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int CNT_W = DEF_CNT_W
`ifdef BSEARCH_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 16
`endif
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [W-1:0]     start_lo,
    input  logic [W-1:0]     start_hi,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic [W-1:0]     result,
    output logic [CNT_W-1:0] iter_count,
    output logic             probe_valid,
    output logic [W-1:0]     probe_addr,
    input  logic             probe_ready,
    input  logic             resp_valid,
    input  logic             resp_pred
`ifdef BSEARCH_TIMEOUT_EN
    ,
    output logic             timed_out
`endif
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    state_t         state;
    logic [W-1:0]   lo, hi, cap_hi;
    logic [W-1:0]   step_lo, step_hi;
    logic [W-1:0]   mid, lo_nxt, hi_nxt, mid_nxt;
    logic           last;
    logic           idle_like;

`ifdef BSEARCH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wait_cnt;
`endif

    // While idle the step unit sees the incoming bounds so the first probe
    // address is ready in the cycle start is accepted.
    always_comb begin
        idle_like = (state == IDLE) || (state == DONE);
        step_lo   = idle_like ? start_lo : lo;
        step_hi   = idle_like ? start_hi : hi;
    end

    bsearch_step #(.W(W)) u_step (
        .lo      (step_lo),
        .hi      (step_hi),
        .pred    (resp_pred),
        .mid     (mid),
        .lo_nxt  (lo_nxt),
        .hi_nxt  (hi_nxt),
        .mid_nxt (mid_nxt),
        .last    (last)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            lo          <= '0;
            hi          <= '0;
            cap_hi      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            found       <= 1'b0;
            result      <= '0;
            iter_count  <= '0;
            probe_valid <= 1'b0;
            probe_addr  <= '0;
`ifdef BSEARCH_TIMEOUT_EN
            timed_out   <= 1'b0;
            wait_cnt    <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        lo         <= start_lo;
                        hi         <= start_hi;
                        cap_hi     <= start_hi;
                        iter_count <= '0;
                        found      <= 1'b0;
`ifdef BSEARCH_TIMEOUT_EN
                        timed_out  <= 1'b0;
`endif
                        if (start_lo < start_hi) begin
                            state       <= ISSUE;
                            busy        <= 1'b1;
                            probe_valid <= 1'b1;
                            probe_addr  <= mid;
                        end else begin
                            state  <= DONE;
                            done   <= 1'b1;
                            result <= start_lo;
                        end
                    end
                end
                ISSUE: begin
                    if (probe_ready) begin
                        state       <= WAIT;
                        probe_valid <= 1'b0;
`ifdef BSEARCH_TIMEOUT_EN
                        wait_cnt    <= '0;
`endif
                    end
                end
                WAIT: begin
                    if (resp_valid) begin
                        lo         <= lo_nxt;
                        hi         <= hi_nxt;
                        iter_count <= sat_inc(iter_count);
                        if (last) begin
                            state  <= DONE;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                            result <= lo_nxt;
                            found  <= lo_nxt < cap_hi;
                        end else begin
                            state       <= ISSUE;
                            probe_valid <= 1'b1;
                            probe_addr  <= mid_nxt;
                        end
                    end
`ifdef BSEARCH_TIMEOUT_EN
                    else if (wait_cnt == TW'(TIMEOUT - 1)) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        timed_out <= 1'b1;
                        found     <= 1'b0;
                        result    <= lo;
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
`endif
                end
                default: begin
                    state       <= IDLE;
                    busy        <= 1'b0;
                    probe_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bsearch_ctrl.sv
// Self-checking bench for bsearch_ctrl: directed cases plus randomized searches
// against a threshold predicate, scored by a closed-form expected answer.
module tb_bsearch_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] start_lo = '0;
    logic [31:0] start_hi = '0;
    logic        busy, done, found;
    logic [31:0] result;
    logic [7:0]  iter_count;
    logic        probe_valid;
    logic [31:0] probe_addr;
    logic        probe_ready = 1'b0;
    logic        resp_valid  = 1'b0;
    logic        resp_pred   = 1'b0;
`ifdef BSEARCH_TIMEOUT_EN
    logic        timed_out;
`endif

    bsearch_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .start_lo    (start_lo),
        .start_hi    (start_hi),
        .busy        (busy),
        .done        (done),
        .found       (found),
        .result      (result),
        .iter_count  (iter_count),
        .probe_valid (probe_valid),
        .probe_addr  (probe_addr),
        .probe_ready (probe_ready),
        .resp_valid  (resp_valid),
        .resp_pred   (resp_pred)
`ifdef BSEARCH_TIMEOUT_EN
        ,
        .timed_out   (timed_out)
`endif
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    logic [31:0] addr_q[$];
    int resp_n;
    int last_resp_cyc;
    int done_cyc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Predicate unit is "addr >= thr"; expected answer is the first satisfying
    // address clipped into [lo, hi].
    task automatic run_search(input logic [31:0] lo, input logic [31:0] hi,
                              input logic [31:0] thr, input int stall,
                              input int rdelay, input bit poke, input string tag);
        int cyc;
        int stall_left;
        int wait_left;
        bit stalled;
        bit saw_pv;
        bit in_range;
        logic [31:0] acc;
        logic [31:0] prev;
        logic [31:0] exp_res;
        bit exp_found;
        longint n;
        int bound;

        addr_q.delete();
        resp_n = 0; last_resp_cyc = -1; done_cyc = -1;
        stall_left = stall; wait_left = 0; stalled = 0; saw_pv = 0; in_range = 1;
        acc = '0; prev = '0;

        @(negedge clock);
        start = 1'b1; start_lo = lo; start_hi = hi;
        @(negedge clock);
        cyc = 1;
        if (lo < hi) check({tag, " first_probe_valid"}, probe_valid, 1'b1);
        while (1) begin
            probe_ready = 1'b0; resp_valid = 1'b0; start = 1'b0;
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (cyc > 2000) begin
                checks++; errors++;
                $error("FAIL %s no_done observed=busy expected=done", tag);
                break;
            end
            if (probe_valid) begin
                saw_pv = 1;
                if (stalled) check({tag, " addr_stable"}, probe_addr, prev);
                if (stall_left > 0) begin
                    stall_left--; stalled = 1; prev = probe_addr;
                    if (poke) begin
                        start = 1'b1; start_lo = 32'd0; start_hi = 32'd1;
                    end
                end else begin
                    probe_ready = 1'b1; stalled = 0; acc = probe_addr;
                    addr_q.push_back(probe_addr);
                    if (probe_addr < lo || probe_addr >= hi) in_range = 0;
                    wait_left = rdelay;
                end
            end else if (busy) begin
                if (wait_left > 0) wait_left--;
                else begin
                    resp_valid = 1'b1; resp_pred = (acc >= thr);
                    resp_n++; last_resp_cyc = cyc;
                end
            end
            @(negedge clock);
            cyc++;
        end

        if (lo >= hi) begin
            exp_res = lo;
            exp_found = 0;
        end else begin
            exp_res = (thr <= lo) ? lo : ((thr < hi) ? thr : hi);
            exp_found = (exp_res < hi);
        end
        check({tag, " result"}, result, exp_res);
        check({tag, " found"}, found, exp_found);
        check({tag, " iter_count"}, iter_count, resp_n);
        check({tag, " busy_at_done"}, busy, 1'b0);
        if (lo >= hi) begin
            check({tag, " empty_done_latency"}, done_cyc, 1);
            check({tag, " empty_no_probe"}, saw_pv, 1'b0);
        end else begin
            n = longint'(hi) - longint'(lo);
            bound = 0;
            while (n > 0) begin
                bound++;
                n = n >> 1;
            end
            check({tag, " done_latency"}, done_cyc, last_resp_cyc + 1);
            check({tag, " probe_bound"}, (resp_n <= bound), 1'b1);
            check({tag, " probes_in_range"}, in_range, 1'b1);
        end
        @(negedge clock);
        check({tag, " done_pulse"}, done, 1'b0);
        check({tag, " result_held"}, result, exp_res);
    endtask

    initial begin
        logic [31:0] exp2 [4];
        logic [31:0] exp3 [5];
        logic [31:0] rlo, rhi, rthr;
        int wcnt;
        exp2 = '{32'd8, 32'd12, 32'd14, 32'd15};
        exp3 = '{32'd8, 32'd4, 32'd2, 32'd1, 32'd0};

        repeat (2) @(negedge clock);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_pv", probe_valid, 1'b0);
        check("rst_result", result, 32'd0);
        check("rst_iter", iter_count, 8'd0);
        reset = 1'b1;
        @(negedge clock);
        check("idle_busy", busy, 1'b0);

        run_search(32'd0, 32'd100, 32'd37, 0, 0, 0, "t1");
        check("t1_iter_le7", (iter_count <= 8'd7), 1'b1);

        run_search(32'd0, 32'd16, 32'hFFFF_FFFF, 0, 0, 0, "t2");
        check("t2_nprobes", addr_q.size(), 4);
        for (int i = 0; i < 4 && i < addr_q.size(); i++) check("t2_addr", addr_q[i], exp2[i]);

        run_search(32'd0, 32'd16, 32'd0, 0, 0, 0, "t3");
        check("t3_nprobes", addr_q.size(), 5);
        for (int i = 0; i < 5 && i < addr_q.size(); i++) check("t3_addr", addr_q[i], exp3[i]);

        run_search(32'd5, 32'd5, 32'd0, 0, 0, 0, "t4");
        run_search(32'd9, 32'd3, 32'd0, 0, 0, 0, "t4b");

        run_search(32'd10, 32'd250, 32'd123, 3, 1, 1, "t5");

        run_search(32'hFFFF_FF00, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1, 0, 0, "top_edge");
        run_search(32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, "full_none");

        for (int k = 0; k < 10; k++) begin
            if (k % 4 == 3) begin
                rhi = 32'hFFFF_FFFF;
                rlo = rhi - $urandom_range(0, 200);
            end else begin
                rlo = $urandom_range(0, 100000);
                rhi = rlo + $urandom_range(0, 300);
            end
            rthr = rlo + $urandom_range(0, 310) - 32'd5;
            run_search(rlo, rhi, rthr, $urandom_range(0, 2), $urandom_range(0, 2), k[0], "rnd");
        end

        // Reset while WAIT is outstanding
        @(negedge clock);
        start = 1'b1; start_lo = 32'd0; start_hi = 32'd100;
        @(negedge clock);
        start = 1'b0; probe_ready = 1'b1;
        @(negedge clock);
        probe_ready = 1'b0;
        check("pre_rst_busy", busy, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_pv", probe_valid, 1'b0);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_found", found, 1'b0);
        check("mid_rst_result", result, 32'd0);
        check("mid_rst_iter", iter_count, 8'd0);
        @(negedge clock);
        reset = 1'b1;
        resp_valid = 1'b1; resp_pred = 1'b1;
        @(negedge clock);
        resp_valid = 1'b0;
        check("stray_resp_busy", busy, 1'b0);
        check("stray_resp_done", done, 1'b0);
        check("stray_resp_iter", iter_count, 8'd0);

        run_search(32'd3, 32'd40, 32'd20, 0, 0, 0, "after_rst");

`ifdef BSEARCH_TIMEOUT_EN
        @(negedge clock);
        start = 1'b1; start_lo = 32'd0; start_hi = 32'd100;
        @(negedge clock);
        start = 1'b0; probe_ready = 1'b1;
        @(negedge clock);
        probe_ready = 1'b0;
        wcnt = 1;
        while (!done && wcnt < 100) begin
            @(negedge clock);
            wcnt++;
        end
        check("to_latency", wcnt, 17);
        check("to_timed_out", timed_out, 1'b1);
        check("to_found", found, 1'b0);
        check("to_result", result, 32'd0);
        run_search(32'd0, 32'd8, 32'd3, 0, 0, 0, "to_clear");
        check("to_cleared", timed_out, 1'b0);
`else
        wcnt = 0;
        check("no_timeout_cnt", wcnt, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
